pwm_rx: RTL and testbench

//  Measures an incoming PWM waveform: high time, low time and period, in clk cycles.

---
 rtl/pwm_rx.sv | 146 ++++++++++++++
 tb/tb_pwm_rx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pwm_rx.sv
// PWM capture: synchronises and deglitches pwm_in, then publishes the high time, low time and
// period of each complete cycle. A watchdog flags an input that stops toggling.
module pwm_rx #(
   parameter int CNT_WIDTH  = 16,
   parameter int FILTER_LEN = 3,
   parameter int TIMEOUT    = 2000
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 enable,
   input  logic                 pwm_in,
   output logic [CNT_WIDTH-1:0] on_time,
   output logic [CNT_WIDTH-1:0] off_time,
   output logic [CNT_WIDTH:0]   period,
   output logic                 meas_valid,
   output logic                 timeout,
   output logic                 stuck_level,
   output logic                 level,
   output logic [1:0]           fsm_state
);

   // meas_valid is a one-cycle strobe with no ready: the consumer must take the triple that cycle.
   typedef enum logic [1:0] {SETTLE = 2'd0, ARM = 2'd1, HIGH = 2'd2, LOW = 2'd3} state_t;

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int SW = $clog2(FILTER_LEN + 2);
   localparam logic [FW-1:0]        F_LAST   = FW'(FILTER_LEN - 1);
   localparam logic [SW-1:0]        S_LAST   = SW'(FILTER_LEN + 1);
   localparam logic [CNT_WIDTH-1:0] WD_LIMIT = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

   state_t               state, state_nxt;
   logic                 sync1, s, filt, filt_d;
   logic [FW-1:0]        fcnt;
   logic [SW-1:0]        scnt;
   logic                 arm_low;
   logic [CNT_WIDTH-1:0] cnt, hi, wd;
   logic                 rise, fall, wd_hit;
   logic                 start_high, end_high, end_low, wd_fire, counting;

   // Synchroniser and glitch filter; both edges see the same delay, so widths are preserved.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync1  <= 1'b0;
         s      <= 1'b0;
         filt   <= 1'b0;
         filt_d <= 1'b0;
         fcnt   <= '0;
      end else begin
         sync1  <= pwm_in;
         s      <= sync1;
         filt_d <= filt;
         if (s != filt) begin
            if (fcnt == F_LAST) begin
               filt <= s;
               fcnt <= '0;
            end else begin
               fcnt <= fcnt + 1'b1;
            end
         end else begin
            fcnt <= '0;
         end
      end
   end

   assign rise      = filt & ~filt_d;
   assign fall      = ~filt & filt_d;
   assign level     = filt;
   assign wd_hit    = (wd == WD_LIMIT) && !rise && !fall;
   assign fsm_state = state;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= SETTLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SETTLE:  if (scnt == S_LAST) state_nxt = ARM;
         ARM:     if (rise && arm_low) state_nxt = HIGH;
         HIGH:    if (fall) state_nxt = LOW;
         LOW:     if (rise) state_nxt = HIGH;
         default: state_nxt = SETTLE;
      endcase
      if (state != SETTLE && wd_hit) state_nxt = ARM;
      if (!enable) state_nxt = SETTLE;
   end

   always_comb begin
      start_high = enable && (state == ARM) && rise && arm_low;
      end_high   = enable && (state == HIGH) && fall;
      end_low    = enable && (state == LOW) && rise;
      wd_fire    = enable && (state != SETTLE) && wd_hit;
      counting   = (state == HIGH) || (state == LOW);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         scnt        <= '0;
         arm_low     <= 1'b0;
         cnt         <= '0;
         hi          <= '0;
         wd          <= '0;
         on_time     <= '0;
         off_time    <= '0;
         period      <= '0;
         meas_valid  <= 1'b0;
         timeout     <= 1'b0;
         stuck_level <= 1'b0;
      end else begin
         meas_valid <= 1'b0;

         if (state == SETTLE && enable && scnt != S_LAST) scnt <= scnt + 1'b1;
         else                                             scnt <= '0;

         // A rise only opens a measurement once the input has been seen low while armed.
         if (state == ARM) arm_low <= arm_low | ~filt;
         else              arm_low <= 1'b0;

         if (start_high || end_high || end_low) cnt <= CNT_WIDTH'(1);
         else if (!counting)                    cnt <= '0;
         else if (cnt != CNT_MAX)               cnt <= cnt + 1'b1;

         if (end_high) hi <= cnt;

         if (end_low) begin
            on_time    <= hi;
            off_time   <= cnt;
            period     <= {1'b0, hi} + {1'b0, cnt};
            meas_valid <= 1'b1;
         end

         if (!enable || state == SETTLE || rise || fall) wd <= '0;
         else if (wd != WD_LIMIT)                        wd <= wd + 1'b1;

         if (wd_fire) begin
            timeout     <= 1'b1;
            stuck_level <= filt;
         end else if (enable && state != SETTLE && rise) begin
            timeout <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pwm_rx.sv
// Directed bench for pwm_rx: the driver pushes each expected on/off/period triple when it drives
// the completing rise; a negedge monitor pops and compares on every meas_valid pulse.
module tb_pwm_rx;
   localparam int CW = 16;
   localparam int PW = CW + 1;
   localparam int EW = 2 * CW + PW;

   logic          clk = 1'b0;
   logic          n_rst, enable, pwm_in;
   logic [CW-1:0] on_time, off_time;
   logic [CW:0]   period;
   logic          meas_valid, timeout, stuck_level, level;
   logic [1:0]    fsm_state;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] exp_e;
   int unsigned   pulse_cyc[$];
   int unsigned   cyc = 0;
   int unsigned   r2, c0, r;
   int            n_vec = 0;
   int            n_err = 0;

   pwm_rx #(.CNT_WIDTH(CW), .FILTER_LEN(3), .TIMEOUT(2000)) dut (
      .clk(clk), .n_rst(n_rst), .enable(enable), .pwm_in(pwm_in),
      .on_time(on_time), .off_time(off_time), .period(period),
      .meas_valid(meas_valid), .timeout(timeout), .stuck_level(stuck_level),
      .level(level), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input int on, input int off);
      exp_q.push_back({CW'(on), CW'(off), PW'(on + off)});
   endtask

   task automatic hold(input logic v, input int n);
      pwm_in = v;
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (meas_valid === 1'b1) begin
         pulse_cyc.push_back(cyc);
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_pulse: got on=%0d off=%0d period=%0d at cycle %0d, expected no pulse",
                     on_time, off_time, period, cyc);
         end else begin
            exp_e = exp_q.pop_front();
            if ({on_time, off_time, period} !== exp_e) begin
               n_err++;
               $display("FAIL triple: got on=%0d off=%0d period=%0d, expected on=%0d off=%0d period=%0d (cycle %0d)",
                        on_time, off_time, period, exp_e[EW-1 -: CW], exp_e[PW +: CW], exp_e[PW-1:0], cyc);
            end
         end
      end
   end

   initial begin
      n_rst = 1'b0; enable = 1'b0; pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_on", on_time, 0);
      check("rst_off", off_time, 0);
      check("rst_period", period, 0);
      check("rst_valid", meas_valid, 0);
      check("rst_timeout", timeout, 0);
      check("rst_stuck", stuck_level, 0);
      check("rst_level", level, 0);
      check("rst_state", fsm_state, 0);
      n_rst = 1'b1; enable = 1'b1;
      hold(0, 20);

      // Steady 30/70: first pulse 6 clk after the second rise is driven, then every 100 clk.
      hold(1, 30); hold(0, 70);
      r2 = cyc; push_exp(30, 70); hold(1, 30); hold(0, 70);
      push_exp(30, 70); hold(1, 30); hold(0, 70);
      push_exp(30, 70); hold(1, 30);
      check("t1_npulse", pulse_cyc.size(), 3);
      if (pulse_cyc.size() >= 3) begin
         check("t1_latency", pulse_cyc[0], r2 + 6);
         check("t1_gap1", pulse_cyc[1] - pulse_cyc[0], 100);
         check("t1_gap2", pulse_cyc[2] - pulse_cyc[1], 100);
      end

      // 2-cycle glitch dropped; 3-cycle pulse accepted and splits the period.
      hold(0, 20); hold(1, 2); hold(0, 48);
      push_exp(30, 70); hold(1, 30);
      hold(0, 20);
      push_exp(30, 20); hold(1, 3);
      hold(0, 47);
      push_exp(3, 47); hold(1, 30);
      hold(0, 70);
      push_exp(30, 70); hold(1, 30);

      // Stuck low: timeout lands exactly 2007 clk after the fall is driven.
      c0 = cyc; pwm_in = 1'b0;
      repeat (2006) @(negedge clk);
      check("t3_timeout_early", timeout, 0);
      @(negedge clk);
      check("t3_timeout_set", timeout, 1);
      check("t3_stuck_level", stuck_level, 0);
      check("t3_state_arm", fsm_state, 1);
      check("t3_on_held", on_time, 30);
      check("t3_period_held", period, 100);
      hold(0, 2100 - 2007);
      r = cyc; pwm_in = 1'b1;
      repeat (5) @(negedge clk);
      check("t3_timeout_pre_rise", timeout, 1);
      @(negedge clk);
      check("t3_timeout_clear", timeout, 0);
      check("t3_clear_cycle", cyc - r, 6);
      repeat (24) @(negedge clk);
      hold(0, 70);
      push_exp(30, 70); hold(1, 30);
      hold(0, 20);

      // Input high across reset release: truncated high phase must not measure.
      pwm_in = 1'b1; n_rst = 1'b0;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      hold(1, 40); hold(0, 70);
      hold(1, 30); hold(0, 70);
      push_exp(30, 70); hold(1, 10);
      check("t4_on", on_time, 30);
      check("t4_level_high", level, 1);

      // Asynchronous reset mid-HIGH.
      #2 n_rst = 1'b0;
      #1;
      check("t5_on", on_time, 0);
      check("t5_off", off_time, 0);
      check("t5_period", period, 0);
      check("t5_level", level, 0);
      check("t5_valid", meas_valid, 0);
      check("t5_state", fsm_state, 0);
      @(negedge clk);
      n_rst = 1'b1;
      hold(1, 20); hold(0, 70);
      hold(1, 30); hold(0, 70);
      push_exp(30, 70); hold(1, 30);
      hold(0, 20);

      // Disable mid-LOW: no pulses, triple held, level keeps tracking.
      enable = 1'b0;
      hold(0, 10); hold(1, 20);
      check("t6_level_tracks", level, 1);
      check("t6_on_held", on_time, 30);
      check("t6_off_held", off_time, 70);
      check("t6_period_held", period, 100);
      check("t6_state", fsm_state, 0);
      hold(0, 40);
      enable = 1'b1;
      hold(0, 30);
      hold(1, 30); hold(0, 70);
      push_exp(30, 70); hold(1, 30);
      hold(0, 20);

      repeat (20) @(negedge clk);
      check("drain", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
